// File: rtl/mem_req_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_seq
//  Purpose  : Queues read/write commands in a small circular FIFO and replays
//             them, one outstanding at a time, onto a simple req/busy memory
//             bus. Each read returns a one-cycle rspValid pulse with its data.
//  Ports    : clk, reset (async, active-high)
//             cmdValid/cmdReady/cmdWr/cmdAddr/cmdData : command push side
//             rspValid/rspData                        : read response
//             memAddr/memDataIn/wr/req/memBusy/memDataOut : memory bus
//             seqIdle     : FIFO empty and sequencer idle
//             errTimeout  : sticky WAIT timeout flag
//  Options  : REQ_TIMEOUT_EN - enables the WAIT timeout counter. Without it,
//             errTimeout is tied low and WAIT lasts until memBusy drops.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_req_seq #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWr,
  input  logic [ADDR_W-1:0] cmdAddr,
  input  logic [DATA_W-1:0] cmdData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  output logic              wr,
  output logic              req,
  input  logic              memBusy,
  input  logic [DATA_W-1:0] memDataOut,
  output logic              seqIdle,
  output logic              errTimeout
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

  // Parameter legality is checked at elaboration.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_param
      $error("mem_req_seq: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [C_ENT_W-1:0]   r_fifo [DEPTH];
  logic [C_PTR_W-1:0]   r_wptr;
  logic [C_PTR_W-1:0]   r_rptr;
  logic [C_CNT_W-1:0]   r_count;
  logic [C_ENT_W-1:0]   w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_done;

  logic                 r_req;
  logic                 r_wr;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_data;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  assign cmdReady = (r_count != C_FULL);
  assign w_push   = cmdValid && cmdReady;
  assign w_head   = r_fifo[r_rptr];

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {cmdWr, cmdAddr, cmdData};
    end
  end

  // DEPTH is a power of 2, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
`ifdef REQ_TIMEOUT_EN
  localparam int C_TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT - 1);

  logic [C_TMR_W-1:0]   r_wait_cnt;
  logic                 r_err;
  logic                 w_timeout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
`ifdef REQ_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // A push into an empty FIFO is not visible here until the next edge,
        // because r_count is still zero during the push cycle.
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!memBusy) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef REQ_TIMEOUT_EN
        // r_wait_cnt holds (WAIT edge number - 1), so this is the TIMEOUT-th edge.
        else if (r_wait_cnt == C_TMR_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered bus and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      // req is high exactly during the ISSUE cycle that follows a pop.
      r_req       <= w_pop;
      r_rsp_valid <= 1'b0;
      if (w_pop) begin
        {r_wr, r_addr, r_wdata} <= w_head;
      end
      if (w_done && !r_wr) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= memDataOut;
      end
`ifdef REQ_TIMEOUT_EN
      // An abandoned read still answers, with zero data, so the requester
      // never waits on a response that will not come.
      if (w_timeout && !r_wr) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= '0;
      end
`endif
    end
  end

`ifdef REQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + C_TMR_W'(1);
      if (w_timeout)              r_err      <= 1'b1;
    end
  end

  assign errTimeout = r_err;
`else
  assign errTimeout = 1'b0;
`endif

  assign req       = r_req;
  assign wr        = r_wr;
  assign memAddr   = r_addr;
  assign memDataIn = r_wdata;
  assign rspValid  = r_rsp_valid;
  assign rspData   = r_rsp_data;
  assign seqIdle   = (r_state == S_IDLE) && (r_count == '0);

endmodule
`default_nettype wire
